// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/exec sequencer around an external 16-bit ALU.
// Owns IP, IR, an 8x16 register file and the n/z/p condition register.
module cpu_sequencer #(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] alu_opcode,
  output logic [15:0] alu_regA,
  output logic [15:0] alu_regB,
  output logic [15:0] alu_imm,
  output logic [15:0] alu_IP,
  input  logic [15:0] alu_res,
  output logic [2:0]  nzp,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ip;
  logic [15:0] r_ir;
  logic [15:0] r_addr;
  logic [2:0]  r_nzp;
  logic [15:0] r_rf [8];

  logic [3:0]  w_op;
  logic [2:0]  w_dr;
  logic [2:0]  w_sr1;
  logic [2:0]  w_sr2;
  logic [15:0] w_rega;
  logic [15:0] w_regb;
  logic [15:0] w_br_off;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_is_ld;
  logic        w_is_br;
  logic        w_is_jmp;
  logic        w_is_nop;
  logic        w_is_halt;
  logic        w_we;
  logic [15:0] w_wdata;
  logic [2:0]  w_nzp_nxt;
  logic [15:0] w_ip_nxt;
  logic        w_retire;

  function automatic logic [2:0] f_nzp(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

  assign w_op  = r_ir[15:12];
  assign w_dr  = r_ir[11:9];
  assign w_sr1 = r_ir[8:6];
  assign w_sr2 = r_ir[2:0];

  assign w_is_alu  = (w_op <= 4'd9);
  assign w_is_cmp  = (w_op == 4'hA);
  assign w_is_ld   = (w_op == 4'hB);
  assign w_is_br   = (w_op == 4'hC);
  assign w_is_jmp  = (w_op == 4'hD);
  assign w_is_nop  = (w_op == 4'hE);
  assign w_is_halt = (w_op == 4'hF);

  // Shifts and LD use IR[8] as a mode bit, so operand A comes from DR.
  assign w_rega = (w_op == 4'h8 || w_op == 4'h9 || w_is_ld)
                ? r_rf[w_dr] : r_rf[w_sr1];
  assign w_regb = r_rf[w_sr2];

  assign w_br_off = {{7{r_ir[8]}}, r_ir[8:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wdata     = 16'h0000;
    w_nzp_nxt   = r_nzp;
    w_ip_nxt    = r_ip;
    w_retire    = 1'b0;
    unique case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
        w_ip_nxt    = r_ip + 16'd1;
        unique case (1'b1)
          w_is_alu: begin
            w_we    = 1'b1;
            w_wdata = alu_res;
          end
          w_is_cmp: begin
            if ($signed(w_rega) < $signed(w_regb))
              w_nzp_nxt = 3'b100;
            else if (w_rega == w_regb)
              w_nzp_nxt = 3'b010;
            else
              w_nzp_nxt = 3'b001;
          end
          w_is_ld: begin
            w_we    = 1'b1;
            w_wdata = r_ir[8] ? w_regb : {8'h00, r_ir[7:0]};
          end
          w_is_br: begin
            if ((w_dr & r_nzp) != 3'b000)
              w_ip_nxt = r_ip + 16'd1 + w_br_off;
          end
          w_is_jmp: w_ip_nxt = r_rf[w_sr1];
          w_is_nop: w_ip_nxt = r_ip + 16'd1;
          w_is_halt: begin
            w_ip_nxt    = r_ip;
            w_state_nxt = S_HALT;
          end
        endcase
        if (w_we)
          w_nzp_nxt = f_nzp(w_wdata);
      end
      S_HALT: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ip    <= RESET_IP;
      r_ir    <= 16'h0000;
      r_addr  <= RESET_IP;
      r_nzp   <= 3'b010;
      for (int i = 0; i < 8; i++)
        r_rf[i] <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH)
        r_addr <= r_ip;
      if (r_state == S_DECODE)
        r_ir <= imem_rdata;
      // Next address is presented at commit so the memory can be read in FETCH.
      if (w_retire) begin
        r_ip   <= w_ip_nxt;
        r_addr <= w_ip_nxt;
        r_nzp  <= w_nzp_nxt;
        if (w_we)
          r_rf[w_dr] <= w_wdata;
      end
    end
  end

  assign imem_addr  = r_addr;
  assign alu_opcode = r_ir;
  assign alu_regA   = w_rega;
  assign alu_regB   = w_regb;
  assign alu_imm    = {{11{r_ir[4]}}, r_ir[4:0]};
  assign alu_IP     = r_ip;
  assign nzp        = r_nzp;
  assign retire     = w_retire;
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench with a program-level reference model,
// a synchronous instruction memory and a behavioural ALU.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] alu_opcode;
  logic [15:0] alu_regA;
  logic [15:0] alu_regB;
  logic [15:0] alu_imm;
  logic [15:0] alu_IP;
  logic [15:0] alu_res;
  logic [2:0]  nzp;
  logic        retire;
  logic        halted;

  cpu_sequencer #(.RESET_IP(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .alu_opcode (alu_opcode),
    .alu_regA   (alu_regA),
    .alu_regB   (alu_regB),
    .alu_imm    (alu_imm),
    .alu_IP     (alu_IP),
    .alu_res    (alu_res),
    .nzp        (nzp),
    .retire     (retire),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [15:0] alu_f(input logic [15:0] ir,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] imm);
    logic [15:0] bb;
    bb = ir[5] ? imm : b;
    case (ir[15:12])
      4'h0: return a + bb;
      4'h1: return ~a;
      4'h2: return a - bb;
      4'h3: return a & bb;
      4'h4: return a | bb;
      4'h5: return a ^ bb;
      4'h6: return 16'(a * bb);
      4'h7: return (bb == 16'h0) ? 16'hFFFF : a / bb;
      4'h8: return a << bb[3:0];
      4'h9: return a >> bb[3:0];
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_opcode, alu_regA, alu_regB, alu_imm);

  typedef struct {
    logic [15:0] ip;
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [2:0]  nzp0;
    logic [2:0]  nzp1;
    logic [15:0] nip;
    logic        halt;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state, one instruction per call.
  logic [15:0] m_R [8];
  logic [2:0]  m_nzp;
  logic [15:0] m_ip;
  logic        m_halt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_R[i] = 16'h0;
    m_nzp  = 3'b010;
    m_ip   = 16'h0000;
    m_halt = 1'b0;
  endtask

  task automatic model_step();
    exp_t        e;
    logic [15:0] ir, a, b, imm, v, nip;
    int          op, dr, sr1, sr2, sa, sb;
    bit          wr;
    ir  = mem[m_ip];
    op  = int'(ir[15:12]);
    dr  = int'(ir[11:9]);
    sr1 = int'(ir[8:6]);
    sr2 = int'(ir[2:0]);
    a   = (op == 8 || op == 9 || op == 11) ? m_R[dr] : m_R[sr1];
    b   = m_R[sr2];
    imm = 16'(int'($signed(ir[4:0])));
    e.ip = m_ip; e.ir = ir; e.a = a; e.b = b; e.imm = imm; e.nzp0 = m_nzp;
    wr  = 0;
    v   = 16'h0;
    nip = 16'(int'(m_ip) + 1);
    if (op <= 9) begin
      v  = alu_f(ir, a, b, imm);
      wr = 1;
    end else if (op == 10) begin
      sa = int'($signed(m_R[sr1]));
      sb = int'($signed(m_R[sr2]));
      m_nzp = (sa < sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
    end else if (op == 11) begin
      v  = ir[8] ? m_R[sr2] : {8'h00, ir[7:0]};
      wr = 1;
    end else if (op == 12) begin
      if ((ir[11:9] & m_nzp) != 3'b000)
        nip = 16'(int'(m_ip) + 1 + int'($signed(ir[8:0])));
    end else if (op == 13) begin
      nip = m_R[sr1];
    end else if (op == 15) begin
      nip    = m_ip;
      m_halt = 1'b1;
    end
    if (wr) begin
      m_R[dr] = v;
      m_nzp   = ($signed(v) < 0) ? 3'b100 : (v == 16'h0) ? 3'b010 : 3'b001;
    end
    m_ip   = nip;
    e.nzp1 = m_nzp;
    e.nip  = nip;
    e.halt = m_halt;
    q.push_back(e);
  endtask

  // Monitor: pre-commit view at each retire, post-commit view one cycle later.
  bit mon_en  = 0;
  bit pending = 0;
  int cyc     = 0;
  int last_ret = -1;
  int ret_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pending  = 0;
      last_ret = -1;
    end else if (mon_en) begin
      if (pending) begin
        check("post_nzp", 32'(nzp), 32'(cur.nzp1));
        check("post_addr", 32'(imem_addr), 32'(cur.nip));
        check("post_halted", 32'(halted), 32'(cur.halt));
        pending = 0;
      end
      if (retire) begin
        ret_cnt++;
        if (last_ret >= 0) check("retire_spacing", cyc - last_ret, 3);
        last_ret = cyc;
        check("q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          check("ex_ir", 32'(alu_opcode), 32'(cur.ir));
          check("ex_ip", 32'(alu_IP), 32'(cur.ip));
          check("ex_regA", 32'(alu_regA), 32'(cur.a));
          check("ex_regB", 32'(alu_regB), 32'(cur.b));
          check("ex_imm", 32'(alu_imm), 32'(cur.imm));
          check("ex_nzp", 32'(nzp), 32'(cur.nzp0));
          pending = 1;
        end
      end
    end
  end

  task automatic wait_halted(input string name, input int bound);
    int t;
    t = 0;
    while (!halted && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(halted), 1);
  endtask

  initial begin
    int t;
    int base;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;
    mem[16'h0000] = 16'hB27F;
    mem[16'h0001] = 16'h0441;
    mem[16'h0002] = 16'h2641;
    mem[16'h0003] = 16'hB280;
    mem[16'h0004] = 16'h8228;
    mem[16'h0005] = 16'hB401;
    mem[16'h0006] = 16'hA042;
    mem[16'h0007] = 16'h06FF;
    mem[16'h000F] = 16'h06E1;
    mem[16'h0010] = 16'hC5FE;
    mem[16'h0011] = 16'hB812;
    mem[16'h0012] = 16'h8828;
    mem[16'h0013] = 16'hBC34;
    mem[16'h0014] = 16'h4906;
    mem[16'h0015] = 16'hD100;
    mem[16'h1234] = 16'hF000;
    model_reset();
    for (int k = 0; k < 200 && !m_halt; k++) model_step();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_nzp", 32'(nzp), 32'(3'b010));
    check("rst_retire", 32'(retire), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_opcode", 32'(alu_opcode), 0);
    check("rst_regA", 32'(alu_regA), 0);
    check("rst_regB", 32'(alu_regB), 0);
    check("rst_imm", 32'(alu_imm), 0);
    check("rst_ip", 32'(alu_IP), 0);
    mon_en = 1;
    rst = 1'b0;
    @(negedge clk);
    check("lat_cycle2", 32'(retire), 0);
    @(negedge clk);
    check("lat_cycle3", 32'(retire), 1);

    wait_halted("p1_halt", 600);
    repeat (20) begin
      @(negedge clk);
      check("halt_retire", 32'(retire), 0);
      check("halt_addr", 32'(imem_addr), 32'h1234);
      check("halt_hold", 32'(halted), 1);
    end
    check("p1_drain", q.size(), 0);

    mon_en = 0;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++)
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    model_reset();
    q.delete();
    for (int k = 0; k < 300; k++) model_step();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1;
    rst = 1'b0;
    t = 0;
    while ((q.size() != 0 || pending) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("p2_drain", q.size(), 0);
    mon_en = 0;

    rst = 1'b1;
    mem[16'h0000] = 16'h0682;
    mem[16'h0001] = 16'hB405;
    mem[16'h0002] = 16'h0482;
    mem[16'h0003] = 16'hF000;
    model_reset();
    q.delete();
    model_step();
    model_step();
    repeat (2) @(posedge clk);
    @(negedge clk);
    base = ret_cnt;
    mon_en = 1;
    rst = 1'b0;
    t = 0;
    while (ret_cnt < base + 2 && t < 60) begin
      @(posedge clk);
      t++;
    end
    check("p3_two_retired", 32'(ret_cnt - base), 2);
    @(negedge clk);
    @(negedge clk);
    mon_en = 0;
    @(negedge clk);
    check("abort_in_exec", 32'(retire), 1);
    check("abort_opcode", 32'(alu_opcode), 32'h0482);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_addr", 32'(imem_addr), 0);
    check("abort_ip", 32'(alu_IP), 0);
    check("abort_nzp", 32'(nzp), 32'(3'b010));
    check("abort_retire", 32'(retire), 0);
    check("abort_halted", 32'(halted), 0);
    model_reset();
    q.delete();
    for (int k = 0; k < 10 && !m_halt; k++) model_step();
    mon_en = 1;
    rst = 1'b0;
    @(negedge clk);
    check("p3_cycle2", 32'(retire), 0);
    @(negedge clk);
    check("p3_cycle3", 32'(retire), 1);
    wait_halted("p3_halt", 100);
    @(negedge clk);
    check("p3_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
